// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the control payload
// carried through both pipeline stages of pipelined_alu.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_ADC   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_SBC   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_NOT   = 4'd7;
    localparam logic [3:0] ALU_SHL   = 4'd8;
    localparam logic [3:0] ALU_SHR   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef struct packed {
        logic [3:0] op;
        logic       set_flags;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b, cin) -> (result, {N,Z,C,V}, illegal).
// C is carry for additions and borrow for subtractions.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags,
    output logic             o_illegal
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    logic [SH_W-1:0] w_sh;
    logic            w_cin_add;
    logic            w_cin_sub;
    logic [WIDTH:0]  w_sum;
    logic [WIDTH:0]  w_diff;
    logic [WIDTH:0]  w_shl;
    logic [WIDTH:0]  w_shr;
    logic [WIDTH:0]  w_sra;
    logic [WIDTH-1:0] w_res;
    logic            w_c;
    logic            w_v;

    assign w_sh      = i_b[SH_W-1:0];
    assign w_cin_add = (i_op == ALU_ADC) & i_cin;
    assign w_cin_sub = (i_op == ALU_SBC) & i_cin;

    // Bit WIDTH of the difference is set exactly when a < b + cin (borrow).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_cin_add};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, w_cin_sub};

    // One guard bit on the far side of each shift catches the last bit shifted
    // out; it is naturally 0 when the shift amount is 0.
    assign w_shl = {1'b0, i_a} << w_sh;
    assign w_shr = {i_a, 1'b0} >> w_sh;
    assign w_sra = $signed({i_a, 1'b0}) >>> w_sh;

    always_comb begin
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            ALU_ADD, ALU_ADC: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[MSB] == i_b[MSB]) & (w_sum[MSB] != i_a[MSB]);
            end
            ALU_SUB, ALU_SBC: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[WIDTH];
                w_v   = (i_a[MSB] != i_b[MSB]) & (w_diff[MSB] != i_a[MSB]);
            end
            ALU_AND:   w_res = i_a & i_b;
            ALU_OR:    w_res = i_a | i_b;
            ALU_XOR:   w_res = i_a ^ i_b;
            ALU_NOT:   w_res = ~i_b;
            ALU_SHL: begin
                w_res = w_shl[MSB:0];
                w_c   = w_shl[WIDTH];
            end
            ALU_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            ALU_SRA: begin
                w_res = w_sra[WIDTH:1];
                w_c   = w_sra[0];
            end
            ALU_PASSB: w_res = i_b;
            default:   o_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_flags        = '0;
        o_flags[FLG_N] = w_res[MSB];
        o_flags[FLG_Z] = (w_res == '0);
        o_flags[FLG_C] = w_c;
        o_flags[FLG_V] = w_v;
    end

    assign o_result = w_res;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU: S1 holds the accepted operation, S2 holds the
// computed result; carries the NZCV register with carry forwarding from S2.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags_q
);

    logic             r_s1_valid;
    alu_ctrl_t        r_s1_ctrl;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [3:0]       r_s2_flags;
    logic             r_s2_illegal;
    logic             r_s2_set_flags;
    logic [TAG_W-1:0] r_s2_tag;

    logic [3:0]       r_flags;

    logic             w_s2_adv;
    logic             w_retire;
    logic             w_cin;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;
    logic             w_illegal;

    assign w_s2_adv = !r_s2_valid | out_ready;
    assign in_ready = !flush & (!r_s1_valid | w_s2_adv);
    assign w_retire = r_s2_valid & out_ready & !flush;

    // The op in S2 has not written flags_q yet, so a flag-setting op there
    // supplies the carry; illegal ops never reach flags_q, so they are skipped.
    assign w_cin = (r_s2_valid & r_s2_set_flags & !r_s2_illegal) ? r_s2_flags[FLG_C]
                                                                 : r_flags[FLG_C];

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op      (r_s1_ctrl.op),
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .i_cin     (w_cin),
        .o_result  (w_result),
        .o_flags   (w_flags),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ctrl  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ctrl.op        <= in_op;
                r_s1_ctrl.set_flags <= in_set_flags;
                r_s1_a              <= in_a;
                r_s1_b              <= in_b;
                r_s1_tag            <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid     <= 1'b0;
            r_s2_result    <= '0;
            r_s2_flags     <= '0;
            r_s2_illegal   <= 1'b0;
            r_s2_set_flags <= 1'b0;
            r_s2_tag       <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result    <= w_result;
                r_s2_flags     <= w_flags;
                r_s2_illegal   <= w_illegal;
                r_s2_set_flags <= r_s1_ctrl.set_flags;
                r_s2_tag       <= r_s1_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_retire & r_s2_set_flags & !r_s2_illegal) begin
            r_flags <= r_s2_flags;
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_flags   = r_s2_flags;
    assign out_illegal = r_s2_illegal;
    assign out_tag     = r_s2_tag;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu (WIDTH=32): table of directed vectors, hand-written
// stall/flush/reset sequences, then random traffic against an arithmetic model.
module tb_pipelined_alu;

    localparam int W  = 32;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_set_flags;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_flags;
    logic          out_illegal;
    logic [TW-1:0] out_tag;
    logic [3:0]    flags_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_set_flags (in_set_flags),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_illegal  (out_illegal),
        .out_tag      (out_tag),
        .flags_q      (flags_q)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        ill;
        logic [3:0]  fq;
    } vec_t;

    typedef struct {
        logic [31:0]   res;
        logic [3:0]    fl;
        logic          ill;
        logic [TW-1:0] tag;
        logic [3:0]    fq_after;
    } exp_t;

    vec_t vecs[15];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf, input logic [TW-1:0] tag);
        in_valid     = v;
        in_op        = op;
        in_a         = a;
        in_b         = b;
        in_set_flags = sf;
        in_tag       = tag;
    endtask

    // Reference: flags {N,Z,C,V}; Cin is the carry left by all older operations.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, output logic [31:0] r, output logic [3:0] f,
                                    output logic ill);
        longint      sa, sb, s;
        logic [63:0] u;
        int          sh;
        logic        c, v, ci;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b[4:0]);
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                ci = (op == 4'd1) ? cin : 1'b0;
                u  = 64'(a) + 64'(b) + 64'(ci);
                r  = u[31:0];
                c  = u[32];
                s  = sa + sb + longint'(ci);
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                ci = (op == 4'd3) ? cin : 1'b0;
                r  = a - b - 32'(ci);
                c  = (64'(a) < 64'(b) + 64'(ci));
                s  = sa - sb - longint'(ci);
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~b;
            4'd8: begin
                r = a << sh;
                if (sh != 0) c = a[32-sh];
            end
            4'd9: begin
                r = a >> sh;
                if (sh != 0) c = a[sh-1];
            end
            4'd10: begin
                r = $signed(a) >>> sh;
                if (sh != 0) c = a[sh-1];
            end
            4'd11: r = b;
            default: ill = 1'b1;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]    m_flags;
        logic [3:0]    arch_fq;
        logic [3:0]    r_op;
        logic [31:0]   r_a, r_b, e_res;
        logic [3:0]    e_fl;
        logic          e_ill, r_sf;
        logic [TW-1:0] r_tag;
        exp_t          e;

        //          op     a             b             sf    result        flags    ill   flags_q
        vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b1001, 1'b0, 4'b1001};
        vecs[1]  = '{4'd2,  32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 4'b1010, 1'b0, 4'b1010};
        vecs[2]  = '{4'd3,  32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 4'b0000, 1'b0, 4'b0000};
        vecs[3]  = '{4'd10, 32'h80000010, 32'h00000024, 1'b0, 32'hF8000001, 4'b1000, 1'b0, 4'b0000};
        vecs[4]  = '{4'd8,  32'h80000000, 32'h00000001, 1'b1, 32'h00000000, 4'b0110, 1'b0, 4'b0110};
        vecs[5]  = '{4'd1,  32'h00000001, 32'h00000002, 1'b0, 32'h00000004, 4'b0000, 1'b0, 4'b0110};
        vecs[6]  = '{4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 4'b0000, 1'b0, 4'b0110};
        vecs[7]  = '{4'd5,  32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0100, 1'b0, 4'b0110};
        vecs[8]  = '{4'd6,  32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 32'hF0F0F0F0, 4'b1000, 1'b0, 4'b0110};
        vecs[9]  = '{4'd7,  32'h12345678, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000, 1'b0, 4'b0110};
        vecs[10] = '{4'd9,  32'h80000001, 32'hFFFFFF01, 1'b0, 32'h40000000, 4'b0010, 1'b0, 4'b0110};
        vecs[11] = '{4'd11, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 4'b0100, 1'b0, 4'b0110};
        vecs[12] = '{4'd13, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 4'b0100, 1'b1, 4'b0110};
        vecs[13] = '{4'd8,  32'h80000000, 32'h00000020, 1'b0, 32'h80000000, 4'b1000, 1'b0, 4'b0110};
        vecs[14] = '{4'd0,  32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 4'b0000, 1'b0, 4'b0000};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_flags_q", flags_q, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, TW'(i + 1));
            @(negedge clk);
            drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
            chk("vec_latency", out_valid, 0);
            @(negedge clk);
            chk("vec_valid", out_valid, 1);
            chk("vec_result", out_result, vecs[i].res);
            chk("vec_flags", out_flags, vecs[i].fl);
            chk("vec_illegal", out_illegal, vecs[i].ill);
            chk("vec_tag", out_tag, TW'(i + 1));
            @(negedge clk);
            chk("vec_flags_q", flags_q, vecs[i].fq);
            chk("vec_no_dup", out_valid, 0);
        end

        // 64-bit add split across ADD/ADC with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'hFFFFFFFF, 32'h1, 1'b1, 6'd1);
        @(negedge clk);
        chk("chain_in_ready", in_ready, 1);
        drive(1'b1, 4'd1, 32'h0, 32'h0, 1'b1, 6'd2);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        chk("chain_full_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            chk("chain_stall_valid", out_valid, 1);
            chk("chain_stall_result", out_result, 32'h0);
            chk("chain_stall_tag", out_tag, 6'd1);
            if (k < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        chk("chain_lo_flags", out_flags, 4'b0110);
        @(negedge clk);
        chk("chain_hi_valid", out_valid, 1);
        chk("chain_hi_result", out_result, 32'h1);
        chk("chain_hi_tag", out_tag, 6'd2);
        chk("chain_hi_flags", out_flags, 4'b0000);
        chk("chain_fq_lo", flags_q, 4'b0110);
        @(negedge clk);
        chk("chain_drained", out_valid, 0);
        chk("chain_fq_hi", flags_q, 4'b0000);

        // Flush with both stages full and the consumer ready
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'hFFFFFFFF, 32'h1, 1'b1, 6'd3);
        @(negedge clk);
        drive(1'b1, 4'd0, 32'hFFFFFFFF, 32'h2, 1'b1, 6'd4);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        chk("flush_full", out_valid, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_flags_q", flags_q, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            chk("flush_s1_dropped", out_valid, 0);
        end
        chk("flush_fq_final", flags_q, 4'b0000);

        // Random traffic against the in-order model
        m_flags = 4'b0000;
        arch_fq = 4'b0000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_flags_q", flags_q, arch_fq);
            r_op  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            r_a   = pick_operand();
            r_b   = pick_operand();
            r_sf  = 1'($urandom_range(0, 1));
            r_tag = TW'($urandom);
            drive(($urandom_range(0, 3) != 0), r_op, r_a, r_b, r_sf, r_tag);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd_spurious actual=tag %0h required=no result", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", out_result, e.res);
                    chk("rnd_flags", out_flags, e.fl);
                    chk("rnd_illegal", out_illegal, e.ill);
                    chk("rnd_tag", out_tag, e.tag);
                    arch_fq = e.fq_after;
                end
            end
            if (in_valid && in_ready) begin
                ref_alu(r_op, r_a, r_b, m_flags[1], e_res, e_fl, e_ill);
                if (r_sf && !e_ill) m_flags = e_fl;
                exp_q.push_back('{e_res, e_fl, e_ill, r_tag, m_flags});
            end
        end
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                chk("drain_result", out_result, e.res);
                chk("drain_tag", out_tag, e.tag);
                arch_fq = e.fq_after;
            end
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("drain_flags_q", flags_q, arch_fq);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 4'd0, 32'h7FFFFFFF, 32'h1, 1'b1, 6'd9);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("stall_fq_before", flags_q, 4'b1001);
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'hA5A5A5A5, 32'h1, 1'b1, 6'd10);
        @(negedge clk);
        drive(1'b0, 4'd0, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_result", out_result, 32'hA5A5A5A5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_tag", out_tag, 0);
        chk("arst_flags_q", flags_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
